// File: rtl/store_buffer_unit_if.sv
// Data-memory write-port bundle between the store buffer (master) and memory (slave).
// A request transfers on a rising edge where MemReqValid and MemReqReady are both 1; once raised,
// MemReqValid and its payload stay stable until that edge (no retraction).
interface store_buffer_unit_if #(
  parameter int AW = 32
);
  logic          MemReqValid;
  logic          MemReqReady;
  logic [AW-1:0] MemAddr;
  logic [31:0]   MemWData;
  logic [3:0]    MemBE;

  modport master (
    output MemReqValid,
    output MemAddr,
    output MemWData,
    output MemBE,
    input  MemReqReady
  );

  modport slave (
    input  MemReqValid,
    input  MemAddr,
    input  MemWData,
    input  MemBE,
    output MemReqReady
  );
endinterface

// File: rtl/store_buffer_unit.sv
// Store buffer: aligns sb/sh/sw stores into word lanes and queues them in a FIFO drained to data memory.
// Optional feature macro STORE_FWD_EN adds a load-versus-pending-store hazard compare.
module store_buffer_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MemWriteM,
  input  logic [2:0]    StoreSelect,
  input  logic [AW-1:0] ALU_ResultM,
  input  logic [31:0]   WriteDataM,
  output logic          ReadyM,
  output logic          StallM,
  output logic          MisalignM,
  output logic          Empty,
  store_buffer_unit_if.master memPort
`ifdef STORE_FWD_EN
  ,
  input  logic          MemReadM,
  input  logic [AW-1:0] LoadAddrM,
  output logic          LoadHazardM
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  logic [PW-1:0]   wrPtr;
  logic [PW-1:0]   rdPtr;
  logic [CW-1:0]   count;

  logic [AW-3:0]   wordQ [DEPTH];
  logic [31:0]     dataQ [DEPTH];
  logic [3:0]      beQ   [DEPTH];

  logic [1:0]      byteOffset;
  logic            storeLegal;
  logic [3:0]      alignBe;
  logic [31:0]     alignData;
  logic            enq;
  logic            deq;

  assign byteOffset = ALU_ResultM[1:0];

  always_comb begin
    storeLegal = 1'b0;
    alignBe    = 4'b0000;
    alignData  = 32'h0;
    case (StoreSelect)
      F3_SB: begin
        storeLegal = 1'b1;
        alignBe    = 4'b0001 << byteOffset;
        alignData  = {4{WriteDataM[7:0]}};
      end
      F3_SH: begin
        storeLegal = ~byteOffset[0];
        alignBe    = byteOffset[1] ? 4'b1100 : 4'b0011;
        alignData  = {2{WriteDataM[15:0]}};
      end
      F3_SW: begin
        storeLegal = (byteOffset == 2'b00);
        alignBe    = 4'b1111;
        alignData  = WriteDataM;
      end
      default: begin
        storeLegal = 1'b0;
      end
    endcase
  end

  // A full buffer refuses new stores even when the head drains this same edge.
  assign ReadyM    = (count != FULL_COUNT);
  assign StallM    = MemWriteM & ~ReadyM;
  assign MisalignM = MemWriteM & ~storeLegal;
  assign Empty     = (count == '0);

  assign enq = MemWriteM & storeLegal & ReadyM;
  assign deq = memPort.MemReqValid & memPort.MemReqReady;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        wordQ[i] <= '0;
        dataQ[i] <= '0;
        beQ[i]   <= '0;
      end
    end else begin
      if (enq) begin
        wordQ[wrPtr] <= ALU_ResultM[AW-1:2];
        dataQ[wrPtr] <= alignData;
        beQ[wrPtr]   <= alignBe;
        wrPtr        <= wrPtr + 1'b1;
      end
      if (deq) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head entry drives the memory port directly, so the payload only moves when rdPtr advances.
  assign memPort.MemReqValid = ~Empty;
  assign memPort.MemAddr     = {wordQ[rdPtr], 2'b00};
  assign memPort.MemWData    = dataQ[rdPtr];
  assign memPort.MemBE       = beQ[rdPtr];

`ifdef STORE_FWD_EN
  logic [PW-1:0]    entryAge [DEPTH];
  logic [DEPTH-1:0] hitVec;
  logic [1:0]       unusedLoadOffset;

  assign unusedLoadOffset = LoadAddrM[1:0];

  // An entry is live when its distance from the head is below the occupancy count.
  always_comb begin
    hitVec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entryAge[i] = PW'(i) - rdPtr;
      if (({1'b0, entryAge[i]} < count) && (wordQ[i] == LoadAddrM[AW-1:2])) begin
        hitVec[i] = 1'b1;
      end
    end
  end

  assign LoadHazardM = MemReadM & (|hitVec);
`endif

endmodule

// File: tb/tb_store_buffer_unit.sv
// Directed bench for store_buffer_unit: stimulus pushes expected memory writes, a negedge monitor pops and compares.
// Define STORE_FWD_EN to also exercise the load hazard compare.
module tb_store_buffer_unit;

  logic        clk;
  logic        rst;
  logic        MemWriteM;
  logic [2:0]  StoreSelect;
  logic [31:0] ALU_ResultM;
  logic [31:0] WriteDataM;
  logic        ReadyM;
  logic        StallM;
  logic        MisalignM;
  logic        Empty;
`ifdef STORE_FWD_EN
  logic        MemReadM;
  logic [31:0] LoadAddrM;
  logic        LoadHazardM;
`endif

  store_buffer_unit_if #(.AW(32)) memBus ();

  store_buffer_unit #(.DEPTH(4), .AW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .MemWriteM   (MemWriteM),
    .StoreSelect (StoreSelect),
    .ALU_ResultM (ALU_ResultM),
    .WriteDataM  (WriteDataM),
    .ReadyM      (ReadyM),
    .StallM      (StallM),
    .MisalignM   (MisalignM),
    .Empty       (Empty),
    .memPort     (memBus)
`ifdef STORE_FWD_EN
    ,
    .MemReadM    (MemReadM),
    .LoadAddrM   (LoadAddrM),
    .LoadHazardM (LoadHazardM)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  int popCount = 0;
  logic [67:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [67:0] expItem;
    if (rst && memBus.MemReqValid && memBus.MemReqReady) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL drain_unexpected: got addr %h data %h be %b, expected no request",
                 memBus.MemAddr, memBus.MemWData, memBus.MemBE);
      end else begin
        expItem = exp_q.pop_front();
        if ({memBus.MemAddr, memBus.MemWData, memBus.MemBE} !== expItem) begin
          errors++;
          $display("FAIL drain_entry: got addr %h data %h be %b expected addr %h data %h be %b",
                   memBus.MemAddr, memBus.MemWData, memBus.MemBE,
                   expItem[67:36], expItem[35:4], expItem[3:0]);
        end
      end
      popCount++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_q.push_back({a, d, be});
  endtask

  task automatic issueStore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] expAddr, input logic [31:0] expData,
                            input logic [3:0] expBe);
    int waitCycles;
    waitCycles = 0;
    MemWriteM   = 1'b1;
    StoreSelect = f3;
    ALU_ResultM = addr;
    WriteDataM  = wd;
    @(negedge clk);
    check("store_legal", {31'b0, MisalignM}, 32'd0);
    while (!ReadyM && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    check("store_accept", {31'b0, ReadyM}, 32'd1);
    if (ReadyM) pushExp(expAddr, expData, expBe);
    tick();
    MemWriteM = 1'b0;
  endtask

  task automatic tryIllegal(input logic [2:0] f3, input logic [31:0] addr, input string name);
    MemWriteM   = 1'b1;
    StoreSelect = f3;
    ALU_ResultM = addr;
    WriteDataM  = 32'hFFFF_FFFF;
    @(negedge clk);
    check(name, {31'b0, MisalignM}, 32'd1);
    tick();
    MemWriteM = 1'b0;
    check({name, "_empty"}, {31'b0, Empty}, 32'd1);
    check({name, "_novalid"}, {31'b0, memBus.MemReqValid}, 32'd0);
  endtask

  task automatic waitEmpty();
    for (int i = 0; i < 50 && !Empty; i++) tick();
    check("wait_empty", {31'b0, Empty}, 32'd1);
  endtask

  // stimulus
  initial begin
    int startPops;
    rst = 1'b0;
    MemWriteM = 1'b0;
    StoreSelect = 3'b000;
    ALU_ResultM = 32'h0;
    WriteDataM = 32'h0;
    memBus.MemReqReady = 1'b0;
`ifdef STORE_FWD_EN
    MemReadM = 1'b0;
    LoadAddrM = 32'h0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'b0, memBus.MemReqValid}, 32'd0);
    check("rst_addr", memBus.MemAddr, 32'h0);
    check("rst_wdata", memBus.MemWData, 32'h0);
    check("rst_be", {28'b0, memBus.MemBE}, 32'h0);
    check("rst_empty", {31'b0, Empty}, 32'd1);
    check("rst_ready", {31'b0, ReadyM}, 32'd1);
    rst = 1'b1;
    tick();
    check("idle_misalign", {31'b0, MisalignM}, 32'd0);

    // sb to the top byte lane, one-cycle latency to the memory port
    memBus.MemReqReady = 1'b1;
    issueStore(3'b000, 32'h103, 32'h0000_00AB, 32'h100, 32'hABAB_ABAB, 4'b1000);
    check("sb_latency_valid", {31'b0, memBus.MemReqValid}, 32'd1);
    check("sb_not_empty", {31'b0, Empty}, 32'd0);
    tick();
    check("sb_drained_empty", {31'b0, Empty}, 32'd1);
    check("sb_drained_valid", {31'b0, memBus.MemReqValid}, 32'd0);

    // illegal / misaligned requests are dropped
    tryIllegal(3'b001, 32'h201, "sh_misalign");
    tryIllegal(3'b010, 32'h202, "sw_misalign");
    tryIllegal(3'b011, 32'h200, "f3_illegal");

    // legal mix of widths and lanes
    issueStore(3'b001, 32'h202, 32'h0000_1234, 32'h200, 32'h1234_1234, 4'b1100);
    issueStore(3'b000, 32'h101, 32'h0000_005A, 32'h100, 32'h5A5A_5A5A, 4'b0010);
    issueStore(3'b001, 32'h300, 32'hFFFF_BEEF, 32'h300, 32'hBEEF_BEEF, 4'b0011);
    issueStore(3'b010, 32'h504, 32'hDEAD_BEEF, 32'h504, 32'hDEAD_BEEF, 4'b1111);
    issueStore(3'b000, 32'h700, 32'h1234_5678, 32'h700, 32'h7878_7878, 4'b0001);
    waitEmpty();

    // fill with memory stalled, then a fifth store hits a full buffer
    memBus.MemReqReady = 1'b0;
    issueStore(3'b010, 32'h400, 32'hC0DE_0000, 32'h400, 32'hC0DE_0000, 4'b1111);
    issueStore(3'b010, 32'h404, 32'hC0DE_0001, 32'h404, 32'hC0DE_0001, 4'b1111);
    issueStore(3'b010, 32'h408, 32'hC0DE_0002, 32'h408, 32'hC0DE_0002, 4'b1111);
    issueStore(3'b010, 32'h40C, 32'hC0DE_0003, 32'h40C, 32'hC0DE_0003, 4'b1111);
    MemWriteM   = 1'b1;
    StoreSelect = 3'b010;
    ALU_ResultM = 32'h410;
    WriteDataM  = 32'h5555_AAAA;
    @(negedge clk);
    check("full_ready", {31'b0, ReadyM}, 32'd0);
    check("full_stall", {31'b0, StallM}, 32'd1);
    check("full_head_valid", {31'b0, memBus.MemReqValid}, 32'd1);
    check("full_head_addr", memBus.MemAddr, 32'h400);
    @(negedge clk);
    check("hold_addr", memBus.MemAddr, 32'h400);
    check("hold_wdata", memBus.MemWData, 32'hC0DE_0000);
    @(posedge clk);
    #1;
    memBus.MemReqReady = 1'b1;
    startPops = popCount;
    @(negedge clk);
    check("full_deq_no_bypass", {31'b0, ReadyM}, 32'd0);
    check("full_deq_stall", {31'b0, StallM}, 32'd1);
    @(negedge clk);
    check("after_deq_ready", {31'b0, ReadyM}, 32'd1);
    if (ReadyM) pushExp(32'h410, 32'h5555_AAAA, 4'b1111);
    tick();
    MemWriteM = 1'b0;
    repeat (3) tick();
    check("drain_rate", popCount - startPops, 32'd5);
    check("drain_empty", {31'b0, Empty}, 32'd1);

    // asynchronous reset in the middle of a stalled handshake
    memBus.MemReqReady = 1'b0;
    issueStore(3'b010, 32'h800, 32'h8888_0000, 32'h800, 32'h8888_0000, 4'b1111);
    issueStore(3'b000, 32'h805, 32'h0000_0077, 32'h804, 32'h7777_7777, 4'b0010);
    @(negedge clk);
    check("pre_rst_valid", {31'b0, memBus.MemReqValid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, memBus.MemReqValid}, 32'd0);
    check("async_rst_empty", {31'b0, Empty}, 32'd1);
    check("async_rst_ready", {31'b0, ReadyM}, 32'd1);
    check("async_rst_addr", memBus.MemAddr, 32'h0);
    check("async_rst_be", {28'b0, memBus.MemBE}, 32'h0);
    exp_q.delete();
    startPops = popCount;
    @(posedge clk);
    #3;
    rst = 1'b1;
    memBus.MemReqReady = 1'b1;
    repeat (3) tick();
    check("post_rst_no_stale", {31'b0, memBus.MemReqValid}, 32'd0);
    check("post_rst_no_pops", popCount - startPops, 32'd0);
    issueStore(3'b010, 32'h900, 32'hCAFE_F00D, 32'h900, 32'hCAFE_F00D, 4'b1111);
    waitEmpty();

`ifdef STORE_FWD_EN
    memBus.MemReqReady = 1'b0;
    issueStore(3'b010, 32'h300, 32'h3333_3333, 32'h300, 32'h3333_3333, 4'b1111);
    MemReadM  = 1'b1;
    LoadAddrM = 32'h302;
    #1;
    check("hazard_same_word", {31'b0, LoadHazardM}, 32'd1);
    LoadAddrM = 32'h304;
    #1;
    check("hazard_other_word", {31'b0, LoadHazardM}, 32'd0);
    LoadAddrM = 32'h302;
    memBus.MemReqReady = 1'b1;
    waitEmpty();
    check("hazard_after_drain", {31'b0, LoadHazardM}, 32'd0);
    MemReadM = 1'b0;
`endif

    // final report
    tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
